// File: rtl/spi_slave_if_if.sv
// Purpose: serial pins plus the RAM-facing word/byte signals of the SPI slave front-end.
// Latency: none (signal bundle only).
// Backpressure: none; rx_valid is a strobe and tx_valid is a level from the RAM.
interface spi_slave_if_if #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
);
    logic              MOSI;
    logic              SS_n;
    logic              MISO;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  MOSI,
        input  SS_n,
        input  tx_data,
        input  tx_valid,
        output MISO,
        output rx_data,
        output rx_valid
    );

    modport master (
        output MOSI,
        output SS_n,
        output tx_data,
        output tx_valid,
        input  MISO,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// Purpose: SPI slave; deserialises 10-bit {cmd,payload} words, serialises one RAM read byte on MISO.
// Latency: rx_valid/rx_data one cycle after the 10th bit; read byte loads at E12 or later, MISO bits follow.
// Backpressure: none; tx_valid is waited on (from E12) until SS_n rises, which aborts everything.
module spi_slave_if #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_if_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Read-back sequencing inside READ_DATA once the word is complete.
    typedef enum logic [1:0] {
        TX_OFF   = 2'd0,   // nothing to send (or byte already sent)
        TX_GAP   = 2'd1,   // E11: tx_valid deliberately ignored
        TX_WAIT  = 2'd2,   // E12 onward: first tx_valid loads the byte
        TX_SHIFT = 2'd3    // byte on its way out, MSB first
    } tx_phase_t;

    // bit_cnt counts word bits already shifted; LAST_BIT means the next one completes the word.
    localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);
    localparam logic [3:0] FULL_CNT = 4'(WORD_W);
    localparam logic [3:0] TX_BITS  = 4'(DATA_W);

    state_t              state;
    state_t              state_nxt;
    tx_phase_t           tx_phase;
    logic [3:0]          bit_cnt;
    logic [3:0]          tx_cnt;
    logic [WORD_W-2:0]   rx_shift;
    logic [DATA_W-1:0]   tx_shift;
    logic                rd_addr_seen;
    logic                capturing;

    assign capturing = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: SS_n high always wins outside IDLE; command bit picks the branch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.SS_n) begin
                    state_nxt = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    state_nxt = IDLE;
                end else if (!bus.MOSI) begin
                    state_nxt = WRITE;
                end else if (rd_addr_seen) begin
                    state_nxt = READ_DATA;
                end else begin
                    state_nxt = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word capture, read-address tracking and the MISO read-back shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.MISO     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bit_cnt      <= 4'd0;
            rx_shift     <= '0;
            rd_addr_seen <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= 4'd0;
            tx_phase     <= TX_OFF;
        end else begin
            // Strobe and serial output fall back to 0 unless a branch below drives them.
            bus.rx_valid <= 1'b0;
            bus.MISO     <= 1'b0;

            if (state == IDLE) begin
                tx_phase <= TX_OFF;
                if (!bus.SS_n) begin
                    bit_cnt <= 4'd0;
                end
            end else if (bus.SS_n) begin
                // Frame abort/end: partial word dropped, rd_addr_seen kept.
                tx_phase <= TX_OFF;
            end else begin
                if (state == CHK_CMD) begin
                    rx_shift <= {rx_shift[WORD_W-3:0], bus.MOSI};
                    bit_cnt  <= 4'd1;
                end else if (capturing) begin
                    if (bit_cnt < LAST_BIT) begin
                        rx_shift <= {rx_shift[WORD_W-3:0], bus.MOSI};
                        bit_cnt  <= bit_cnt + 4'd1;
                    end else if (bit_cnt == LAST_BIT) begin
                        bus.rx_data  <= {rx_shift, bus.MOSI};
                        bus.rx_valid <= 1'b1;
                        bit_cnt      <= FULL_CNT;
                        if (state == READ_ADD) begin
                            rd_addr_seen <= 1'b1;
                        end
                        if (state == READ_DATA) begin
                            rd_addr_seen <= 1'b0;
                            tx_phase     <= TX_GAP;
                        end
                    end
                end

                case (tx_phase)
                    TX_GAP: begin
                        tx_phase <= TX_WAIT;
                    end
                    TX_WAIT: begin
                        if (bus.tx_valid) begin
                            tx_shift <= bus.tx_data;
                            tx_cnt   <= TX_BITS;
                            tx_phase <= TX_SHIFT;
                        end
                    end
                    TX_SHIFT: begin
                        bus.MISO <= tx_shift[DATA_W-1];
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        tx_cnt   <= tx_cnt - 4'd1;
                        if (tx_cnt == 4'd1) begin
                            tx_phase <= TX_OFF;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Purpose: directed plus randomised frames against a frame-level reference model of the SPI slave.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: tx_valid timing varied per frame, including a stale-valid case.
module tb_spi_slave_if;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if_if bus ();

    spi_slave_if dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: last completed word and whether a read address is pending.
    logic [9:0] rx_data_m = 10'h000;
    bit         rd_seen_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame edge by edge (edge 0 = SS_n first seen low) and checks every output
    // after every edge against the frame rules, then updates the reference state.
    task automatic run_frame(input logic [9:0] word, input int nbits, input int tail,
                             input int tv_from, input bit stale, input logic [7:0] data,
                             input bit skip_start, input bit b2b_next);
        bit         full;
        bit         rdata;
        int         last;
        int         load_e;
        int         e;
        logic [7:0] ld;
        logic [9:0] hold;
        logic       exp_miso;
        logic       exp_vld;
        logic [9:0] exp_dat;

        full   = (nbits == 10);
        rdata  = full && word[9] && rd_seen_m;
        last   = full ? 10 + tail : nbits;
        load_e = stale ? 12 : ((tv_from < 12) ? 12 : tv_from);
        ld     = (load_e >= tv_from) ? data : 8'h00;
        hold   = rx_data_m;

        for (int k = (skip_start ? 1 : 0); k <= last + 2; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                e        = k - 1;
                exp_miso = 1'b0;
                exp_vld  = 1'b0;
                exp_dat  = hold;
                if (e >= 1 && e <= last) begin
                    if (full && e >= 10) exp_dat = word;
                    if (full && e == 10) exp_vld = 1'b1;
                    if (rdata && e > load_e && e <= load_e + 8)
                        exp_miso = ld[7 - (e - load_e - 1)];
                end else if (e == last + 1 && full) begin
                    exp_dat = word;
                end
                chk("miso", 32'(bus.MISO), 32'(exp_miso));
                chk("rx_valid", 32'(bus.rx_valid), 32'(exp_vld));
                chk("rx_data", 32'(bus.rx_data), 32'(exp_dat));
            end
            if (k <= last) begin
                bus.SS_n     = 1'b0;
                bus.MOSI     = (k >= 1 && k <= 10) ? word[10 - k] : 1'($urandom);
                bus.tx_valid = (k >= tv_from) || stale;
                bus.tx_data  = (k >= tv_from) ? data : 8'h00;
            end else if (k == last + 1) begin
                bus.SS_n = 1'b1;
            end else begin
                bus.SS_n = !b2b_next;
            end
        end

        if (full) begin
            rx_data_m = word;
            if (word[9]) rd_seen_m = !rd_seen_m;
        end
    endtask

    initial begin
        logic [9:0] w;
        bus.MOSI     = 1'b0;
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_miso", 32'(bus.MISO), 32'(1'b0));
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'(1'b0));
        chk("reset_rx_data", 32'(bus.rx_data), 32'(10'h000));
        rst_n = 1'b1;
        @(negedge clk);

        // Write address frames and a read-address frame.
        run_frame(10'h055, 10, 2, 99, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(10'h255, 10, 3, 99, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset mid-WRITE at bit 5; also clears the pending read address.
        w = 10'h0F3;
        @(negedge clk);
        bus.SS_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.MOSI = w[10 - i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_miso", 32'(bus.MISO), 32'(1'b0));
        chk("midreset_rx_valid", 32'(bus.rx_valid), 32'(1'b0));
        chk("midreset_rx_data", 32'(bus.rx_data), 32'(10'h000));
        @(negedge clk);
        bus.SS_n = 1'b1;
        rst_n    = 1'b1;
        rx_data_m = 10'h000;
        rd_seen_m = 1'b0;
        @(negedge clk);
        chk("postreset_rx_data", 32'(bus.rx_data), 32'(10'h000));

        // Next frame decodes normally.
        run_frame(10'h1A5, 10, 1, 99, 1'b0, 8'h00, 1'b0, 1'b0);

        // Read without prior address: READ_ADD, MISO silent despite tx_valid.
        run_frame(10'h3C7, 10, 14, 11, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Read data: tx_valid from E11, loaded at E12, byte A5 streamed; back-to-back next frame.
        run_frame(10'h3E1, 10, 12, 11, 1'b0, 8'hA5, 1'b0, 1'b1);

        // Abort after 6 word bits (starts one cycle after previous frame's SS_n high).
        run_frame(10'h0AB, 6, 0, 99, 1'b0, 8'h00, 1'b1, 1'b0);

        // Stale tx_valid: valid with 00 through E11, real byte 3C from E12.
        run_frame(10'h255, 10, 0, 99, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(10'h312, 10, 13, 12, 1'b1, 8'h3C, 1'b0, 1'b0);

        // Expired wait: read data with tx_valid never rising, MISO stays 0 until SS_n high.
        run_frame(10'h255, 10, 0, 99, 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(10'h3AA, 10, 14, 99, 1'b0, 8'h5A, 1'b0, 1'b0);

        // Randomised frames.
        for (int n = 0; n < 24; n++) begin
            int nb;
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 10;
            run_frame(10'($urandom), nb, $urandom_range(0, 12), $urandom_range(11, 16),
                      1'($urandom_range(0, 3) == 0), 8'($urandom), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
